// File: rtl/alu_seq.sv
// Handshaked, registered ALU with an iterative shift-add unsigned multiplier.
// One operation is in flight at a time: IDLE accepts, MUL iterates, DONE holds the result.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       bonus_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;

    // One adder serves ADD, SUB and SLT; subtraction is A + ~B + 1.
    logic             sub_sel;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             carry_msb_in;
    logic             add_ovf;
    logic             lt, eq, cmp;

    assign sub_sel      = (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
    assign b_eff        = sub_sel ? ~src2 : src2;
    assign sum          = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    assign carry_msb_in = sum[WIDTH-1] ^ src1[WIDTH-1] ^ b_eff[WIDTH-1];
    assign add_ovf      = carry_msb_in ^ sum[WIDTH];
    assign lt           = sum[WIDTH-1] ^ add_ovf;
    assign eq           = (sum[WIDTH-1:0] == '0);

    always_comb begin
        case (bonus_control)
            3'b001:  cmp = !lt && !eq;
            3'b010:  cmp = lt || eq;
            3'b011:  cmp = !lt;
            3'b100:  cmp = eq;
            3'b101:  cmp = !eq;
            default: cmp = lt;
        endcase
    end

    // NOTE: every next-state variable takes its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                    case (ALU_control)
                        OP_AND:  result_d = src1 & src2;
                        OP_OR:   result_d = src1 | src2;
                        OP_NOR:  result_d = ~(src1 | src2);
                        OP_ADD, OP_SUB: begin
                            result_d = sum[WIDTH-1:0];
                            cout_d   = sum[WIDTH];
                            ovf_d    = add_ovf;
                        end
                        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, cmp};
                        OP_MULU: begin
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, src1};
                            mplier_d = src2;
                            count_d  = CW'(WIDTH);
                            state_d  = MUL;
                        end
                        default: result_d = '0;
                    endcase
                end
            end
            MUL: begin
                // Multiplicand is pre-shifted each step, equivalent to shifting by WIDTH - count.
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    result_d = acc_d[WIDTH-1:0];
                    ovf_d    = |acc_d[2*WIDTH-1:WIDTH];
                    cout_d   = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = ~|result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops on WIDTH=32 and WIDTH=8 instances,
// compared against an arithmetic reference model.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid32, in_valid8;
    logic [31:0] src1, src2;
    logic [3:0]  ALU_control;
    logic [2:0]  bonus_control;
    logic        out_ready;

    logic        in_ready32, out_valid32, zero32, cout32, overflow32;
    logic [31:0] result32;
    logic        in_ready8, out_valid8, zero8, cout8, overflow8;
    logic [7:0]  result8;

    int checks = 0;
    int errors = 0;
    logic sel8 = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .src1(src1), .src2(src2), .ALU_control(ALU_control), .bonus_control(bonus_control),
        .out_valid(out_valid32), .out_ready(out_ready), .result(result32),
        .zero(zero32), .cout(cout32), .overflow(overflow32)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .src1(src1[7:0]), .src2(src2[7:0]), .ALU_control(ALU_control), .bonus_control(bonus_control),
        .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
        .zero(zero8), .cout(cout8), .overflow(overflow8)
    );

    wire        rdy = sel8 ? in_ready8   : in_ready32;
    wire        ov  = sel8 ? out_valid8  : out_valid32;
    wire [31:0] res = sel8 ? {24'd0, result8} : result32;
    wire        zf  = sel8 ? zero8       : zero32;
    wire        cf  = sel8 ? cout8       : cout32;
    wire        vf  = sel8 ? overflow8   : overflow32;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [3:0] op, input logic [2:0] bc,
                                  input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [63:0] r, output logic c, output logic v);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned a = a_in & mask;
        longint unsigned b = b_in & mask;
        longint smax = (longint'(1) <<< (w - 1)) - 1;
        longint smin = -smax - 1;
        longint sa = ((a >> (w - 1)) != 0) ? longint'(a) - (longint'(1) <<< w) : longint'(a);
        longint sb = ((b >> (w - 1)) != 0) ? longint'(b) - (longint'(1) <<< w) : longint'(b);
        longint unsigned s;
        bit cmp;
        r = 0; c = 0; v = 0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b) & mask;
            4'b0010: begin
                s = a + b;
                r = s & mask;
                c = ((s >> w) & 1) != 0;
                v = (sa + sb > smax) || (sa + sb < smin);
            end
            4'b0110: begin
                r = (a - b) & mask;
                c = (a >= b);
                v = (sa - sb > smax) || (sa - sb < smin);
            end
            4'b0111: begin
                case (bc)
                    3'b001:  cmp = sa > sb;
                    3'b010:  cmp = sa <= sb;
                    3'b011:  cmp = sa >= sb;
                    3'b100:  cmp = sa == sb;
                    3'b101:  cmp = sa != sb;
                    default: cmp = sa < sb;
                endcase
                r = {63'd0, cmp};
            end
            4'b1000: begin
                s = a * b;
                r = s & mask;
                v = (s >> w) != 0;
            end
            default: ;
        endcase
    endfunction

    // Issues one op, measures latency, optionally holds out_ready low for `hold` cycles
    // while offering a competing operation, then retires the result.
    task automatic run_op(input int w, input logic [3:0] op, input logic [2:0] bc,
                          input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
        logic [63:0] er;
        logic ec, ev;
        int n, lat;
        sel8 = (w == 8);
        model(w, op, bc, a, b, er, ec, ev);
        lat = (op == 4'b1000) ? w + 1 : 1;
        @(negedge clk);
        check({tag, "/in_ready_idle"}, 64'(rdy), 64'd1);
        src1 = a; src2 = b; ALU_control = op; bonus_control = bc;
        if (w == 8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; in_valid32 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (op == 4'b1000) check({tag, "/in_ready_busy"}, 64'(rdy), 64'd0);
        end while (!ov && n < 300);
        if (!ov) begin
            check({tag, "/timeout"}, 64'd0, 64'd1);
            return;
        end
        check({tag, "/latency"},  64'(n),   64'(lat));
        check({tag, "/result"},   64'(res), er);
        check({tag, "/zero"},     64'(zf),  64'(er == 0));
        check({tag, "/cout"},     64'(cf),  64'(ec));
        check({tag, "/overflow"}, 64'(vf),  64'(ev));
        for (int i = 0; i < hold; i++) begin
            src1 = ~a; src2 = 32'd1; ALU_control = 4'b0010;
            if (w == 8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
            @(negedge clk);
            check({tag, "/bp_valid"},  64'(ov),  64'd1);
            check({tag, "/bp_ready"},  64'(rdy), 64'd0);
            check({tag, "/bp_result"}, 64'(res), er);
            check({tag, "/bp_flags"},  {61'd0, zf, cf, vf}, {61'd0, er == 0, ec, ev});
        end
        in_valid8 = 1'b0; in_valid32 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [3:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        rst_n = 1'b0; in_valid32 = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; ALU_control = '0; bonus_control = '0;
        #3;
        check("reset/in_ready",  64'(in_ready32),  64'd1);
        check("reset/out_valid", 64'(out_valid32), 64'd0);
        check("reset/result",    64'(result32),    64'd0);
        check("reset/flags",     {61'd0, zero32, cout32, overflow32}, 64'b100);
        check("reset8/state",    {60'd0, in_ready8, out_valid8, zero8, result8 == 8'd0}, 64'b1011);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32, 4'b0010, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
        run_op(32, 4'b0110, 3'b000, 32'd5, 32'd5, 0, "sub_eq");
        run_op(32, 4'b0110, 3'b000, 32'd0, 32'd1, 0, "sub_borrow");
        run_op(32, 4'b0111, 3'b000, 32'hFFFF_FFFD, 32'd2, 0, "slt_lt");
        run_op(32, 4'b0111, 3'b011, 32'hFFFF_FFFD, 32'd2, 0, "slt_ge");
        run_op(32, 4'b0111, 3'b100, 32'd7, 32'd7, 0, "slt_eq");
        run_op(32, 4'b0111, 3'b111, 32'hFFFF_FFFD, 32'd2, 0, "slt_111");
        run_op(32, 4'b0111, 3'b001, 32'h8000_0000, 32'h7FFF_FFFF, 0, "slt_gt_edge");
        run_op(32, 4'b1000, 3'b000, 32'h0001_0000, 32'h0001_0000, 0, "mul_ovf");
        run_op(32, 4'b1000, 3'b000, 32'd123, 32'd456, 0, "mul_small");
        run_op(32, 4'b0000, 3'b000, 32'hF0F0_1234, 32'hFF00_FF00, 5, "and_bp");
        run_op(32, 4'b1000, 3'b000, 32'hDEAD_BEEF, 32'h0000_0003, 5, "mul_bp");
        run_op(32, 4'b1100, 3'b000, 32'h0F0F_0000, 32'h00F0_00FF, 0, "nor");
        run_op(32, 4'b0011, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "illegal_op");

        // Reset in the middle of a multiply.
        sel8 = 1'b0;
        @(negedge clk);
        src1 = 32'd1000; src2 = 32'd1000; ALU_control = 4'b1000; in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid/busy", 64'(in_ready32), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/out_valid", 64'(out_valid32), 64'd0);
        check("rst_mid/in_ready",  64'(in_ready32),  64'd1);
        check("rst_mid/result",    64'(result32),    64'd0);
        check("rst_mid/flags",     {61'd0, zero32, cout32, overflow32}, 64'b100);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32, 4'b0010, 3'b000, 32'd1, 32'd1, 0, "add_after_rst");

        run_op(8, 4'b1000, 3'b000, 32'hFF, 32'hFF, 0, "w8_mul_ff");
        run_op(8, 4'b0010, 3'b000, 32'h7F, 32'h01, 0, "w8_add_ovf");

        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) rop = (i % 3 == 0) ? 4'b1000 : 4'b0111;
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra & 32'hFF;
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op(32, rop, 3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, 2)), "rand32");
        end
        for (int i = 0; i < 15; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (i % 4 == 0) rop = 4'b1000;
            run_op(8, rop, 3'($urandom_range(0, 7)), $urandom, $urandom, 0, "rand8");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. It keeps the same operation encoding, compare modes and zero/cout/overflow flags, and registers every result. It adds an iterative shift-add multiplier and valid/ready flow control on both sides. It sits between the decode/operand-fetch stage and writeback, so a multi-cycle multiply can stall the front end.

## Interface
- WIDTH, 32, datapath width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  block can accept an operation.
- src1  in  WIDTH  operand A.
- src2  in  WIDTH  operand B.
- ALU_control  in  4  opcode.
- bonus_control  in  3  compare mode, used only by SLT.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  set when result == 0.
- cout  out  1  carry out of the MSB.
- overflow  out  1  signed overflow, or multiply overflow.

## Operation
- Opcode map, sampled at accept:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A + ~B + 1), 1100 NOR.
  - 0111 SLT: result = {0…, cmp}.
  - 1000 MULU: unsigned multiply, low WIDTH bits of the product.
  - Any other opcode: result = 0 and all flags = 0. It still completes as a single-cycle op.
- SLT compare modes (bonus_control), all signed and evaluated on the SUB datapath:
  - 000 lt, 001 gt, 010 le, 011 ge, 100 eq, 101 ne; 110 and 111 behave as lt.
  - lt is computed as sign(A−B) XOR overflow(A−B).
- Flags:
  - ADD/SUB: cout = carry out of bit WIDTH−1; overflow = carry into MSB XOR carry out of MSB.
  - Logic ops and SLT: cout = 0, overflow = 0.
  - MULU: cout = 0; overflow = OR of the upper WIDTH bits of the 2·WIDTH-bit product.
  - zero always reflects the registered result.
- State machine: IDLE, MUL, DONE.
  - IDLE: in_ready = 1. On in_valid, capture the operands and opcode. Single-cycle ops compute and go to DONE. MULU loads the accumulator (2·WIDTH bits) = 0, the multiplicand and the multiplier, sets count = WIDTH, and goes to MUL.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand << (WIDTH − count). Then multiplier >>= 1 and count −= 1. When count reaches 0, latch the result and flags and go to DONE. No early termination: the multiply always takes WIDTH cycles.
  - DONE: out_valid = 1 and result/flags are held. When out_ready is high, go to IDLE.
- in_ready is 0 in both MUL and DONE. Inputs are ignored outside IDLE.

## Timing
- Reset state (asynchronous while rst_n is low): IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 1, cout = 0, overflow = 0, count = 0.
- Accept occurs in cycle T, on the edge where in_valid && in_ready.
  - Single-cycle op: out_valid is high from T+1.
  - MULU: out_valid is high from T+1+WIDTH (WIDTH = 32 gives 33).
- Back-to-back operation: a result taken at edge U gives in_ready = 1 in cycle U+1. Throughput is at most one op per 2 cycles.
- Backpressure: while out_valid && !out_ready, result and all flags are held bit-stable.
- All outputs come straight from registers. No combinational path exists from in_* to out_*.
- rst_n asserted mid-MUL or in DONE aborts the op immediately and returns to the reset state. The in-flight result is lost and is not replayed.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 accepted at T -> at T+1: out_valid = 1, result = 0x80000000, overflow = 1, cout = 0, zero = 0.
- SUB 5 − 5 -> result = 0, zero = 1, cout = 1, overflow = 0. SUB 0 − 1 -> 0xFFFFFFFF, cout = 0.
- SLT with A = −3 (0xFFFFFFFD), B = 2:
  - bonus 000 -> 1.
  - bonus 011 -> 0.
  - bonus 100 with A = B = 7 -> 1.
  - bonus 111 behaves as lt -> 1.
- MULU 0x00010000 × 0x00010000 -> out_valid exactly at T+33, result = 0, zero = 1, overflow = 1. Then 123 × 456 -> 56088, overflow = 0, and in_ready stays 0 for cycles T+1..T+33.
- Backpressure: out_ready is low for 5 cycles after out_valid -> result, flags and out_valid are stable, and in_ready = 0. A new in_valid presented during this window is not accepted.
- Reset mid-multiply: rst_n low at T+10 of a MULU -> asynchronously out_valid = 0, result = 0, zero = 1, in_ready = 1. After release, ADD 1+1 -> result 2 at the next cycle after accept. WIDTH=8 regression: 0xFF × 0xFF -> 0x01, overflow = 1, latency 9.
